mem_io_responder: RTL
=====================

Name: mem_io_responder

Overview:
- Responder end of the CPU byte-wide memory bus (mem_a / mem_dout / mem_wr out of the CPU, mem_din / io_buffer_full into it).
- Contains the 128 KB program/data RAM, the 0x30000 UART byte port with a TX FIFO and an RX pop path, and the 0x30004 cycle counter / program-stop port.
- Sits between the CPU top and the board UART; the same RTL is used in simulation and on FPGA.

Parameters:
RAM_ADDR_WIDTH, 17, RAM byte-address width (2^17 = 128 KB).
TX_DEPTH_LOG2, 4, log2 of TX FIFO depth (16 entries).
FULL_MARGIN, 2, free entries remaining at which io_buffer_full asserts.

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
bus_a  in  32  CPU address (mem_a); only [17:0] decoded
bus_wdata  in  8  CPU write byte (mem_dout)
bus_wr  in  1  1 = write, 0 = read (mem_wr)
bus_rdata  out  8  read byte to CPU (mem_din)
io_buffer_full  out  1  TX FIFO near full
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  UART accepts tx_data this cycle
rx_data  in  8  head byte from UART receiver
rx_valid  in  1  rx_data is valid
rx_pop  out  1  one-cycle pulse: consume rx_data
program_stop  out  1  sticky: 0x30004 written
cycle_count  out  32  cycles since reset (debug)

Behaviour:
- Clock and reset: one clock clk_in; reset rst_in is asynchronous, active-high.
- Reset values: bus_rdata=0, io_buffer_full=0, tx_valid=0, tx_data=0, rx_pop=0, program_stop=0, cycle_count=0.
- RAM contents are not reset.
- TX FIFO pointers, count and the counter snapshot are cleared by reset.
- Reset asserted mid-operation discards any queued TX bytes.
- Decode:
  - IO when bus_a[17:16]==2'b11.
  - RAM when bus_a[17]==0; RAM index is bus_a[16:0].
  - bus_a[17:16]==2'b10 is unmapped: reads return 0x00, writes are ignored.
- Read latency: exactly 1 cycle. Address A presented at cycle t with bus_wr=0 gives bus_rdata = byte(A) at t+1. Every cycle is a new request; there is no handshake.
- On a write cycle, bus_rdata holds its previous value.
- RAM write: byte written at the clock edge. Read-after-write to the same address in the next cycle returns the new byte.
- IO read 0x30000:
  - rx_pop pulses in the same cycle as the request only if rx_valid=1.
  - bus_rdata at t+1 is rx_data as sampled at t, or 0x00 if rx_valid=0.
- IO read 0x30004..0x30007:
  - Returns byte [addr-0x30004] of the snapshot, little-endian.
  - A read of 0x30004 loads the snapshot from cycle_count in the same edge, and byte 0 comes from the value being loaded. This keeps all 4 bytes coherent.
  - Reads of 0x30005..0x30007 do not reload the snapshot.
- Other IO addresses: reads return 0x00, writes are ignored.
- IO write 0x30000:
  - bus_wdata==0x00 is ignored.
  - Otherwise the byte is pushed to the TX FIFO.
  - Push while the FIFO is completely full: byte is dropped and the FIFO is unchanged.
- IO write 0x30004:
  - Sets program_stop (sticky until reset).
  - Pushes 0x00 into the TX FIFO if it is not full. This is the only path that transmits 0x00.
  - Once program_stop=1, further 0x30004 writes push nothing.
- TX FIFO:
  - Circular buffer of 2^TX_DEPTH_LOG2 bytes.
  - tx_valid = (count!=0); tx_data = head entry.
  - Pop on tx_valid && tx_ready.
  - Simultaneous push and pop when count==depth: the pop is performed and the push is accepted; count is unchanged.
  - Pointers wrap modulo depth.
- io_buffer_full:
  - Registered; equals (count_next >= depth - FULL_MARGIN).
  - The margin covers the CPU seeing the flag one cycle late while a write is in flight.
- cycle_count: increments by 1 each cycle while program_stop==0, freezes once program_stop is set, wraps at 2^32.

Optional Feature:
TX_DROP_CNT_EN:
- Defined: adds output tx_drop_cnt[7:0], reset 0. It increments, saturating at 0xFF, on each nonzero 0x30000 write dropped because the TX FIFO is full.
- Undefined: the port is absent and drops are silent.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 the next cycle -> bus_rdata=0xA5 one cycle after the read address.
- Read 0x20004 -> bus_rdata=0x00; write 0x77 to 0x20004, then read 0x00004 -> RAM byte unchanged.
- With tx_ready=0, write 0x41 to 0x30000 seventeen times -> 16 bytes queued; io_buffer_full=1 after the 14th write; 17th write dropped (tx_drop_cnt=1 when TX_DROP_CNT_EN is defined). Then tx_ready=1 -> 16 bytes of 0x41 drain and io_buffer_full clears.
- Write 0x00 to 0x30000 -> no push, tx_valid stays 0. Write any byte to 0x30004 -> program_stop=1, TX receives 0x00, cycle_count frozen.
- Hold reset for 3 cycles, release, wait 1000 cycles, read 0x30004..0x30007 on consecutive cycles -> the 4 bytes assemble, little-endian, to the counter value at the 0x30004 read cycle (±0 cycles).
- rx_valid=1, rx_data=0x5A, read 0x30000 -> rx_pop high for 1 cycle, bus_rdata=0x5A next cycle. With rx_valid=0, the same read -> no pop, bus_rdata=0x00.

Source files
------------

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus: address/write byte/write strobe from the CPU,
// read byte and TX back-pressure flag returned to it.
interface mem_io_responder_if;
    logic [31:0] bus_a;
    logic [7:0]  bus_wdata;
    logic        bus_wr;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;

    // Valid/ready: none. Every cycle is a new request; reads answer one cycle later.
    modport master (output bus_a, output bus_wdata, output bus_wr,
                    input bus_rdata, input io_buffer_full);
    modport slave  (input bus_a, input bus_wdata, input bus_wr,
                    output bus_rdata, output io_buffer_full);
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the CPU memory bus: 128 KB RAM, UART byte port with TX FIFO, cycle counter/stop port.
// Optional build macro TX_DROP_CNT_EN adds a saturating tx_drop_cnt output.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    mem_io_responder_if.slave bus,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_stop,
    output logic [31:0] cycle_count
`ifdef TX_DROP_CNT_EN
    ,
    output logic [7:0]  tx_drop_cnt
`endif
);
    localparam int CW    = TX_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(DEPTH - FULL_MARGIN);

    localparam logic [1:0] SRC_HOLD = 2'd0;
    localparam logic [1:0] SRC_RAM  = 2'd1;
    localparam logic [1:0] SRC_IO   = 2'd2;

    logic [7:0] ram [0:(1<<RAM_ADDR_WIDTH)-1];
    logic [7:0] ram_rd_q;
    logic [7:0] tx_mem [0:DEPTH-1];

    logic [17:0] addr;
    logic        is_io, is_ram, uart_hit, ctr_hit, stop_hit, wr;
    logic        unused_hi;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;

    logic [1:0]  src_q, src_d;
    logic [7:0]  last_q, last_d;
    logic [7:0]  io_rd_q, io_rd_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] cycle_q, cycle_d;
    logic        stop_q, stop_d;
    logic        full_q, full_d;
    logic [TX_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic        push_req, push_ok, pop;
    logic [7:0]  push_byte;

    assign addr      = bus.bus_a[17:0];
    assign unused_hi = ^bus.bus_a[31:18];
    assign wr        = bus.bus_wr;
    assign ram_idx   = bus.bus_a[RAM_ADDR_WIDTH-1:0];
    assign is_io     = (addr[17:16] == 2'b11);
    assign is_ram    = ~addr[17];
    assign uart_hit  = is_io && (addr[15:0] == 16'h0000);
    assign ctr_hit   = is_io && (addr[15:2] == 14'd1);
    assign stop_hit  = is_io && (addr[15:0] == 16'h0004);

    // RX head is consumed in the same cycle the CPU issues the read.
    assign rx_pop = ~rst_in && ~wr && uart_hit && rx_valid;

    assign tx_valid = (count_q != '0);
    assign tx_data  = tx_valid ? tx_mem[rd_ptr_q] : 8'h00;
    assign program_stop       = stop_q;
    assign cycle_count        = cycle_q;
    assign bus.io_buffer_full = full_q;

    // Read byte is steered from the RAM read register, the IO register, or
    // held at its last value on write cycles.
    always_comb begin
        case (src_q)
            SRC_RAM: bus.bus_rdata = ram_rd_q;
            SRC_IO:  bus.bus_rdata = io_rd_q;
            default: bus.bus_rdata = last_q;
        endcase
    end
    assign last_d = bus.bus_rdata;

    always_comb begin
        src_d   = src_q;
        io_rd_d = io_rd_q;
        snap_d  = snap_q;
        if (wr) begin
            src_d = SRC_HOLD;
        end else if (is_ram) begin
            src_d = SRC_RAM;
        end else begin
            src_d   = SRC_IO;
            io_rd_d = 8'h00;
            if (uart_hit) begin
                io_rd_d = rx_valid ? rx_data : 8'h00;
            end else if (ctr_hit) begin
                // Byte 0 comes from the value being captured so all 4 bytes agree.
                case (addr[1:0])
                    2'd0: begin
                        snap_d  = cycle_q;
                        io_rd_d = cycle_q[7:0];
                    end
                    2'd1:    io_rd_d = snap_q[15:8];
                    2'd2:    io_rd_d = snap_q[23:16];
                    default: io_rd_d = snap_q[31:24];
                endcase
            end
        end
    end

    always_comb begin
        push_req  = wr && ((uart_hit && (bus.bus_wdata != 8'h00)) || (stop_hit && ~stop_q));
        push_byte = uart_hit ? bus.bus_wdata : 8'h00;
        pop       = tx_valid && tx_ready;
        push_ok   = push_req && ((count_q != DEPTH_C) || pop);
        wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d   = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
        full_d  = (count_d >= THRESH_C);
        stop_d  = stop_q | (wr && stop_hit);
        cycle_d = stop_q ? cycle_q : cycle_q + 32'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            src_q    <= SRC_HOLD;
            last_q   <= 8'h00;
            io_rd_q  <= 8'h00;
            snap_q   <= 32'd0;
            cycle_q  <= 32'd0;
            stop_q   <= 1'b0;
            full_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            src_q    <= src_d;
            last_q   <= last_d;
            io_rd_q  <= io_rd_d;
            snap_q   <= snap_d;
            cycle_q  <= cycle_d;
            stop_q   <= stop_d;
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage arrays carry no reset so they map onto block/distributed RAM.
    always_ff @(posedge clk_in) begin
        if (wr && is_ram)  ram[ram_idx] <= bus.bus_wdata;
        if (!wr && is_ram) ram_rd_q <= ram[ram_idx];
        if (push_ok)       tx_mem[wr_ptr_q] <= push_byte;
    end

`ifdef TX_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;
    logic       drop_ev;
    assign drop_ev     = wr && uart_hit && (bus.bus_wdata != 8'h00) && ~push_ok;
    assign drop_d      = (drop_ev && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    assign tx_drop_cnt = drop_q;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) drop_q <= 8'h00;
        else        drop_q <= drop_d;
    end
`endif
endmodule
